// File: rtl/batch_issuer_pkg.sv
// Shared scheduler widths, batch issuer state encodings and field bundle.
// Latency: none (types and constants only).
// Backpressure: not applicable.

`ifndef DRAM_SCHEDULER_TYPES_VH
`define DRAM_SCHEDULER_TYPES_VH
`define BANK_GROUP_WIDTH 2
`define BANK_WIDTH       2
`define ROW_WIDTH        16
`define COLUMN_WIDTH     10
`define MISS_TAG_WIDTH   (`BANK_GROUP_WIDTH + `BANK_WIDTH)
`define MAX_REQUESTS     16
`define REQUEST_ID_WIDTH 5
`endif

`ifndef BI_STATE_DEFINES
`define BI_STATE_DEFINES
`define BI_IDLE    3'd0
`define BI_READ    3'd1
`define BI_CAPTURE 3'd2
`define BI_ISSUE   3'd3
`define BI_CLEAR   3'd4
`define NUM_BANKS  (1 << `MISS_TAG_WIDTH)
`endif

package batch_issuer_pkg;

    typedef enum logic [2:0] {
        BI_ST_IDLE    = `BI_IDLE,
        BI_ST_READ    = `BI_READ,
        BI_ST_CAPTURE = `BI_CAPTURE,
        BI_ST_ISSUE   = `BI_ISSUE,
        BI_ST_CLEAR   = `BI_CLEAR
    } bi_state_t;

    // Address fields of one buffered request, carried as one bundle.
    typedef struct packed {
        logic [`BANK_GROUP_WIDTH-1:0] bank_group;
        logic [`BANK_WIDTH-1:0]       bank;
        logic [`ROW_WIDTH-1:0]        row;
        logic [`COLUMN_WIDTH-1:0]     column;
    } req_hdr_t;

endpackage

// File: rtl/batch_issuer_open_row_table.sv
// Per-bank open-row table: one write port, one combinational hit lookup.
// Latency: writes visible the cycle after wr_en; lookup is combinational.
// Backpressure: none; clear_all then the write both apply on the same edge.

module open_row_table #(
    parameter int NUM_BANKS = `NUM_BANKS,
    parameter int TAG_W     = `MISS_TAG_WIDTH,
    parameter int ROW_W     = `ROW_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_all,
    input  logic             wr_en,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [ROW_W-1:0] wr_row,
    input  logic [TAG_W-1:0] lk_tag,
    input  logic [ROW_W-1:0] lk_row,
    output logic             lk_hit
);

    logic [NUM_BANKS-1:0] valid_q;
    logic [ROW_W-1:0]     row_q [NUM_BANKS];

    // Invalidate everything on clear_all, then let a same-cycle write reopen its bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < NUM_BANKS; i++) begin
                row_q[i] <= '0;
            end
        end else begin
            if (clear_all) begin
                valid_q <= '0;
            end
            if (wr_en) begin
                valid_q[wr_tag] <= 1'b1;
                row_q[wr_tag]   <= wr_row;
            end
        end
    end

    assign lk_hit = valid_q[lk_tag] && (row_q[lk_tag] == lk_row);

endmodule

// File: rtl/batch_issuer.sv
// Drains the request buffer in index order onto a valid/ready command port.
// Latency: 3 cycles per entry minimum (READ, CAPTURE, ISSUE); clear pulse after last handshake.
// Backpressure: cmd_* held stable in ISSUE until cmd_ready; buffer read index holds meanwhile.

module batch_issuer
    import batch_issuer_pkg::*;
#(
    parameter int MAX_REQUESTS = `MAX_REQUESTS,
    parameter int NUM_BANKS    = `NUM_BANKS
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          batch_go,
    input  logic                          precharge_all,
    input  logic [`REQUEST_ID_WIDTH-1:0]  num_requests,
    output logic                          batch_start,
    output logic                          batch_clear,
    output logic [`REQUEST_ID_WIDTH-1:0]  rd_addr,
    input  logic [`BANK_GROUP_WIDTH-1:0]  rd_bank_group,
    input  logic [`BANK_WIDTH-1:0]        rd_bank,
    input  logic [`ROW_WIDTH-1:0]         rd_row,
    input  logic [`COLUMN_WIDTH-1:0]      rd_column,
    input  logic [`MISS_TAG_WIDTH-1:0]    rd_miss_tag,
    output logic                          cmd_valid,
    input  logic                          cmd_ready,
    output logic [`BANK_GROUP_WIDTH-1:0]  cmd_bank_group,
    output logic [`BANK_WIDTH-1:0]        cmd_bank,
    output logic [`ROW_WIDTH-1:0]         cmd_row,
    output logic [`COLUMN_WIDTH-1:0]      cmd_column,
    output logic                          cmd_row_hit,
    output logic [`REQUEST_ID_WIDTH-1:0]  cmd_req_id,
    output logic                          busy,
    output logic                          batch_done
);

    localparam int IDW = `REQUEST_ID_WIDTH;
    localparam logic [IDW-1:0] ONE   = IDW'(1);
    localparam logic [IDW-1:0] MAX_Q = IDW'(MAX_REQUESTS);

    bi_state_t                  state_q;
    logic [IDW-1:0]             idx_q;
    logic [IDW-1:0]             last_q;
    logic [IDW-1:0]             rd_addr_q;
    logic                       batch_start_q;
    logic                       batch_clear_q;
    logic                       batch_done_q;
    logic                       cmd_valid_q;
    req_hdr_t                   cmd_q;
    logic [`MISS_TAG_WIDTH-1:0] cmd_tag_q;
    logic [IDW-1:0]             cmd_req_id_q;
    logic                       cmd_row_hit_q;

    logic                       hs;
    logic                       lk_hit;
    logic [IDW-1:0]             occupancy;

    assign hs        = (state_q == BI_ST_ISSUE) && cmd_valid_q && cmd_ready;
    // Occupancy beyond the buffer depth cannot be real; clamp so the walk stays in range.
    assign occupancy = (num_requests > MAX_Q) ? MAX_Q : num_requests;

    open_row_table #(
        .NUM_BANKS (NUM_BANKS),
        .TAG_W     (`MISS_TAG_WIDTH),
        .ROW_W     (`ROW_WIDTH)
    ) u_table (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_all (precharge_all),
        .wr_en     (hs),
        .wr_tag    (cmd_tag_q),
        .wr_row    (cmd_q.row),
        .lk_tag    (rd_miss_tag),
        .lk_row    (rd_row),
        .lk_hit    (lk_hit)
    );

    // Batch walk FSM; every output is a register updated on the transition that needs it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= BI_ST_IDLE;
            idx_q         <= '0;
            last_q        <= '0;
            rd_addr_q     <= '0;
            batch_start_q <= 1'b0;
            batch_clear_q <= 1'b0;
            batch_done_q  <= 1'b0;
            cmd_valid_q   <= 1'b0;
            cmd_q         <= '0;
            cmd_tag_q     <= '0;
            cmd_req_id_q  <= '0;
            cmd_row_hit_q <= 1'b0;
        end else begin
            batch_clear_q <= 1'b0;
            batch_done_q  <= 1'b0;
            case (state_q)
                BI_ST_IDLE: begin
                    if (batch_go) begin
                        if (occupancy != '0) begin
                            last_q        <= occupancy - ONE;
                            idx_q         <= '0;
                            rd_addr_q     <= '0;
                            batch_start_q <= 1'b1;
                            state_q       <= BI_ST_READ;
                        end else begin
                            // Empty batch: still acknowledge with a clear pulse.
                            batch_clear_q <= 1'b1;
                            batch_done_q  <= 1'b1;
                            state_q       <= BI_ST_CLEAR;
                        end
                    end
                end
                BI_ST_READ: begin
                    state_q <= BI_ST_CAPTURE;
                end
                BI_ST_CAPTURE: begin
                    cmd_q.bank_group <= rd_bank_group;
                    cmd_q.bank       <= rd_bank;
                    cmd_q.row        <= rd_row;
                    cmd_q.column     <= rd_column;
                    cmd_tag_q        <= rd_miss_tag;
                    cmd_req_id_q     <= idx_q;
                    cmd_row_hit_q    <= lk_hit;
                    cmd_valid_q      <= 1'b1;
                    state_q          <= BI_ST_ISSUE;
                end
                BI_ST_ISSUE: begin
                    if (hs) begin
                        cmd_valid_q <= 1'b0;
                        if (idx_q == last_q) begin
                            batch_start_q <= 1'b0;
                            batch_clear_q <= 1'b1;
                            batch_done_q  <= 1'b1;
                            state_q       <= BI_ST_CLEAR;
                        end else begin
                            idx_q     <= idx_q + ONE;
                            rd_addr_q <= idx_q + ONE;
                            state_q   <= BI_ST_READ;
                        end
                    end
                end
                BI_ST_CLEAR: begin
                    state_q <= BI_ST_IDLE;
                end
                default: begin
                    state_q <= BI_ST_IDLE;
                end
            endcase
        end
    end

    assign busy           = (state_q != BI_ST_IDLE);
    assign batch_start    = batch_start_q;
    assign batch_clear    = batch_clear_q;
    assign batch_done     = batch_done_q;
    assign rd_addr        = rd_addr_q;
    assign cmd_valid      = cmd_valid_q;
    assign cmd_bank_group = cmd_q.bank_group;
    assign cmd_bank       = cmd_q.bank;
    assign cmd_row        = cmd_q.row;
    assign cmd_column     = cmd_q.column;
    assign cmd_row_hit    = cmd_row_hit_q;
    assign cmd_req_id     = cmd_req_id_q;

endmodule

// File: tb/tb_batch_issuer.sv
// Directed bench for batch_issuer with a registered-read buffer model.
// Latency: observes 3-cycle issue spacing and clear pulse timing.
// Backpressure: a driver process stalls cmd_ready on chosen entries.

`timescale 1ns/1ps

module tb_batch_issuer;
    import batch_issuer_pkg::*;

    localparam int IDW = `REQUEST_ID_WIDTH;

    logic                          clk = 1'b0;
    logic                          rst_n = 1'b0;
    logic                          batch_go = 1'b0;
    logic                          precharge_all = 1'b0;
    logic [IDW-1:0]                num_requests = '0;
    logic                          batch_start;
    logic                          batch_clear;
    logic [IDW-1:0]                rd_addr;
    logic [`BANK_GROUP_WIDTH-1:0]  rd_bank_group = '0;
    logic [`BANK_WIDTH-1:0]        rd_bank = '0;
    logic [`ROW_WIDTH-1:0]         rd_row = '0;
    logic [`COLUMN_WIDTH-1:0]      rd_column = '0;
    logic [`MISS_TAG_WIDTH-1:0]    rd_miss_tag = '0;
    logic                          cmd_valid;
    logic                          cmd_ready = 1'b0;
    logic [`BANK_GROUP_WIDTH-1:0]  cmd_bank_group;
    logic [`BANK_WIDTH-1:0]        cmd_bank;
    logic [`ROW_WIDTH-1:0]         cmd_row;
    logic [`COLUMN_WIDTH-1:0]      cmd_column;
    logic                          cmd_row_hit;
    logic [IDW-1:0]                cmd_req_id;
    logic                          busy;
    logic                          batch_done;

    batch_issuer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .batch_go       (batch_go),
        .precharge_all  (precharge_all),
        .num_requests   (num_requests),
        .batch_start    (batch_start),
        .batch_clear    (batch_clear),
        .rd_addr        (rd_addr),
        .rd_bank_group  (rd_bank_group),
        .rd_bank        (rd_bank),
        .rd_row         (rd_row),
        .rd_column      (rd_column),
        .rd_miss_tag    (rd_miss_tag),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_bank_group (cmd_bank_group),
        .cmd_bank       (cmd_bank),
        .cmd_row        (cmd_row),
        .cmd_column     (cmd_column),
        .cmd_row_hit    (cmd_row_hit),
        .cmd_req_id     (cmd_req_id),
        .busy           (busy),
        .batch_done     (batch_done)
    );

    always #5 clk = ~clk;

    // Buffer contents and its registered read port.
    logic [`BANK_GROUP_WIDTH-1:0] m_bg  [32];
    logic [`BANK_WIDTH-1:0]       m_b   [32];
    logic [`ROW_WIDTH-1:0]        m_row [32];
    logic [`COLUMN_WIDTH-1:0]     m_col [32];

    always @(posedge clk) begin
        rd_bank_group <= m_bg[rd_addr];
        rd_bank       <= m_b[rd_addr];
        rd_row        <= m_row[rd_addr];
        rd_column     <= m_col[rd_addr];
        rd_miss_tag   <= {m_bg[rd_addr], m_b[rd_addr]};
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Handshake and clear-pulse recorder.
    int hs_id[$];
    int hs_hit[$];
    int hs_cyc[$];
    int clr_cnt = 0;
    int clr_cyc = 0;
    always @(negedge clk) begin
        if (cmd_valid && cmd_ready) begin
            hs_id.push_back(int'(cmd_req_id));
            hs_hit.push_back(int'(cmd_row_hit));
            hs_cyc.push_back(cyc);
        end
        if (batch_clear) begin
            clr_cnt = clr_cnt + 1;
            clr_cyc = cyc;
        end
    end

    // Driver config (main process) and its private counters (driver process).
    int stall_id = -1;
    int stall_len = 0;
    int pc_id = -1;
    int ready_en = 1;
    int cfg_gen = 0;

    initial begin
        int seen_gen;
        int stall_cnt;
        int pc_done;
        seen_gen  = 0;
        stall_cnt = 0;
        pc_done   = 0;
        forever begin
            @(posedge clk);
            #1;
            if (cfg_gen != seen_gen) begin
                seen_gen  = cfg_gen;
                stall_cnt = 0;
                pc_done   = 0;
            end
            if (cmd_valid && int'(cmd_req_id) == stall_id && stall_cnt < stall_len) begin
                cmd_ready = 1'b0;
                stall_cnt = stall_cnt + 1;
            end else begin
                cmd_ready = (ready_en != 0);
            end
            if (pc_done == 0 && cmd_valid && int'(cmd_req_id) == pc_id) begin
                precharge_all = 1'b1;
                pc_done       = 1;
            end else begin
                precharge_all = 1'b0;
            end
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int q_at(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    task automatic load_entry(input int i, input int bg, input int b, input int row);
        m_bg[i]  = `BANK_GROUP_WIDTH'(bg);
        m_b[i]   = `BANK_WIDTH'(b);
        m_row[i] = `ROW_WIDTH'(row);
        m_col[i] = `COLUMN_WIDTH'(100 + i);
    endtask

    // Returns #1 after the edge that samples batch_go.
    task automatic start_batch(input int n, input int s_id, input int s_len, input int p_id,
                               output int go_cyc);
        num_requests = IDW'(n);
        stall_id     = s_id;
        stall_len    = s_len;
        pc_id        = p_id;
        cfg_gen      = cfg_gen + 1;
        @(posedge clk);
        #1 batch_go = 1'b1;
        @(posedge clk);
        #1 batch_go = 1'b0;
        go_cyc = cyc;
    endtask

    task automatic wait_done(input string tag, input int max);
        int found;
        found = 0;
        for (int k = 0; k < max && found == 0; k++) begin
            @(negedge clk);
            if (batch_clear) found = 1;
        end
        check_eq(tag, found, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid_id(input string tag, input int id, input int max);
        int found;
        found = 0;
        for (int k = 0; k < max && found == 0; k++) begin
            @(negedge clk);
            if (cmd_valid && int'(cmd_req_id) == id) found = 1;
        end
        check_eq(tag, found, 1);
    endtask

    initial begin
        int go_cyc;
        int hb;
        int cb;

        for (int i = 0; i < 32; i++) load_entry(i, 0, 0, 0);

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_cmd_valid", cmd_valid, 0);
        check_eq("rst_batch_start", batch_start, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_batch_clear", batch_clear, 0);
        check_eq("rst_rd_addr", rd_addr, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Empty batch: straight IDLE -> CLEAR, single pulse, nothing issued
        hb = hs_id.size();
        cb = clr_cnt;
        start_batch(0, -1, 0, -1, go_cyc);
        check_eq("empty_clear_hi", batch_clear, 1);
        check_eq("empty_done_hi", batch_done, 1);
        check_eq("empty_start_lo", batch_start, 0);
        @(posedge clk);
        #1;
        check_eq("empty_clear_lo", batch_clear, 0);
        check_eq("empty_busy_lo", busy, 0);
        repeat (3) @(negedge clk);
        check_eq("empty_clr_count", clr_cnt - cb, 1);
        check_eq("empty_no_issue", hs_id.size() - hb, 0);

        // Three entries, ready high: ids 0,1,2 every 3 cycles, hits 0,1,0
        load_entry(0, 0, 0, 5);
        load_entry(1, 0, 0, 5);
        load_entry(2, 1, 2, 9);
        hb = hs_id.size();
        start_batch(3, -1, 0, -1, go_cyc);
        check_eq("b1_start_hi", batch_start, 1);
        check_eq("b1_rd_addr0", rd_addr, 0);
        wait_done("b1_done_seen", 40);
        check_eq("b1_count", hs_id.size() - hb, 3);
        check_eq("b1_id0", q_at(hs_id, hb), 0);
        check_eq("b1_id1", q_at(hs_id, hb + 1), 1);
        check_eq("b1_id2", q_at(hs_id, hb + 2), 2);
        check_eq("b1_hit0", q_at(hs_hit, hb), 0);
        check_eq("b1_hit1", q_at(hs_hit, hb + 1), 1);
        check_eq("b1_hit2", q_at(hs_hit, hb + 2), 0);
        check_eq("b1_first_lat", q_at(hs_cyc, hb) - go_cyc, 2);
        check_eq("b1_gap01", q_at(hs_cyc, hb + 1) - q_at(hs_cyc, hb), 3);
        check_eq("b1_gap12", q_at(hs_cyc, hb + 2) - q_at(hs_cyc, hb + 1), 3);
        check_eq("b1_clear_at", clr_cyc - q_at(hs_cyc, hb + 2), 1);
        check_eq("b1_clear_lo", batch_clear, 0);
        check_eq("b1_start_lo", batch_start, 0);

        // Same batch, entry 1 stalled 4 cycles: everything frozen; table now hits all three
        hb = hs_id.size();
        start_batch(3, 1, 4, -1, go_cyc);
        wait_valid_id("b2_reach_e1", 1, 30);
        for (int k = 0; k < 4; k++) begin
            check_eq("b2_stall_valid", cmd_valid, 1);
            check_eq("b2_stall_ready", cmd_ready, 0);
            check_eq("b2_stall_id", cmd_req_id, 1);
            check_eq("b2_stall_row", cmd_row, 5);
            check_eq("b2_stall_col", cmd_column, 101);
            check_eq("b2_stall_hit", cmd_row_hit, 1);
            check_eq("b2_stall_rdaddr", rd_addr, 1);
            @(negedge clk);
        end
        wait_done("b2_done_seen", 40);
        check_eq("b2_count", hs_id.size() - hb, 3);
        check_eq("b2_id0", q_at(hs_id, hb), 0);
        check_eq("b2_id1", q_at(hs_id, hb + 1), 1);
        check_eq("b2_id2", q_at(hs_id, hb + 2), 2);
        check_eq("b2_hit0", q_at(hs_hit, hb), 1);
        check_eq("b2_hit2", q_at(hs_hit, hb + 2), 1);
        check_eq("b2_gap01", q_at(hs_cyc, hb + 1) - q_at(hs_cyc, hb), 7);

        // Persisting table: {bg1,b2} row9 hits, row7 then misses and becomes the open row
        load_entry(0, 1, 2, 9);
        load_entry(1, 1, 2, 7);
        hb = hs_id.size();
        start_batch(2, -1, 0, -1, go_cyc);
        wait_done("b3_done_seen", 30);
        check_eq("b3_hit0", q_at(hs_hit, hb), 1);
        check_eq("b3_hit1", q_at(hs_hit, hb + 1), 0);
        load_entry(0, 1, 2, 7);
        hb = hs_id.size();
        start_batch(1, -1, 0, -1, go_cyc);
        wait_done("b4_done_seen", 30);
        check_eq("b4_row7_open", q_at(hs_hit, hb), 1);

        // Precharge coinciding with entry 0's handshake: that bank stays open, {bg1,b2}
        // (open at row7 beforehand) is invalidated so row7 now misses
        load_entry(0, 0, 0, 5);
        load_entry(1, 0, 0, 5);
        load_entry(2, 1, 2, 7);
        hb = hs_id.size();
        start_batch(3, -1, 0, 0, go_cyc);
        wait_done("b5_done_seen", 40);
        check_eq("b5_count", hs_id.size() - hb, 3);
        check_eq("b5_hit0", q_at(hs_hit, hb), 1);
        check_eq("b5_hit1", q_at(hs_hit, hb + 1), 1);
        check_eq("b5_hit2", q_at(hs_hit, hb + 2), 0);

        // Reset during ISSUE of entry 1 of 4
        load_entry(0, 0, 0, 5);
        load_entry(1, 0, 0, 5);
        load_entry(2, 1, 2, 7);
        load_entry(3, 1, 2, 7);
        start_batch(4, 1, 1000, -1, go_cyc);
        wait_valid_id("b6_reach_e1", 1, 30);
        cb = clr_cnt;
        rst_n = 1'b0;
        #1;
        check_eq("b6_rst_valid", cmd_valid, 0);
        check_eq("b6_rst_start", batch_start, 0);
        check_eq("b6_rst_busy", busy, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("b6_no_clear", clr_cnt - cb, 0);
        check_eq("b6_idle", busy, 0);
        load_entry(0, 0, 0, 5);
        load_entry(1, 0, 0, 5);
        hb = hs_id.size();
        start_batch(2, -1, 0, -1, go_cyc);
        check_eq("b6_restart_rdaddr", rd_addr, 0);
        check_eq("b6_restart_start", batch_start, 1);
        wait_done("b6_done_seen", 30);
        check_eq("b6_id0", q_at(hs_id, hb), 0);
        check_eq("b6_id1", q_at(hs_id, hb + 1), 1);
        check_eq("b6_hit0", q_at(hs_hit, hb), 0);
        check_eq("b6_hit1", q_at(hs_hit, hb + 1), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
